// File: rtl/image_pixel_streamer_pkg.sv
// Shared types and defaults for the frame source at the head of the Canny pipeline.
// Width helper keeps degenerate 1-pixel dimensions at a legal 1-bit field.
package image_pixel_streamer_pkg;

    localparam int IMG_WIDTH_DEF  = 512;
    localparam int IMG_HEIGHT_DEF = 512;
    localparam int ITEM_SIZE_DEF  = 8;

    typedef logic [ITEM_SIZE_DEF-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        DONE
    } streamer_state_t;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/image_pixel_streamer_if.sv
// Control, frame-memory read port and raster pixel stream of the streamer.
// master = streamer side, slave = memory / pixel_loader / controller side.
interface image_pixel_streamer_if
    import image_pixel_streamer_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int ITEM_SIZE  = ITEM_SIZE_DEF
) ();

    localparam int ADDR_W = width_of(IMG_WIDTH * IMG_HEIGHT);
    localparam int X_W    = width_of(IMG_WIDTH);
    localparam int Y_W    = width_of(IMG_HEIGHT);

    logic                 start;
    logic                 stall;
    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_addr;
    logic [ITEM_SIZE-1:0] mem_rd_data;
    logic [ITEM_SIZE-1:0] pixel_out;
    logic                 pixel_out_valid;
    logic [X_W-1:0]       pixel_x;
    logic [Y_W-1:0]       pixel_y;
    logic                 frame_start;
    logic                 frame_end;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, stall, mem_rd_data,
        output mem_rd_en, mem_addr, pixel_out, pixel_out_valid,
               pixel_x, pixel_y, frame_start, frame_end, busy, done
    );

    modport slave (
        output start, stall, mem_rd_data,
        input  mem_rd_en, mem_addr, pixel_out, pixel_out_valid,
               pixel_x, pixel_y, frame_start, frame_end, busy, done
    );

endinterface

// File: rtl/image_pixel_streamer_raster_xy_counter.sv
// Raster-order x/y position counter; wraps to (0,0) after the last pixel of the frame.
module raster_xy_counter #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int X_W        = 9,
    parameter int Y_W        = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inc,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           first,
    output logic           last
);

    logic x_at_end;
    logic y_at_end;

    assign x_at_end = (x == X_W'(IMG_WIDTH - 1));
    assign y_at_end = (y == Y_W'(IMG_HEIGHT - 1));
    assign first    = (x == '0) && (y == '0);
    assign last     = x_at_end && y_at_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            if (x_at_end) begin
                x <= '0;
                y <= y_at_end ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_pixel_streamer.sv
// Reads one frame from a 1-cycle synchronous-read memory and emits it in raster order
// with coordinates, frame flags and a start/busy/done handshake; stall holds both stages.
module image_pixel_streamer
    import image_pixel_streamer_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int ITEM_SIZE  = ITEM_SIZE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    image_pixel_streamer_if.master bus
);

    localparam int ADDR_W = width_of(IMG_WIDTH * IMG_HEIGHT);
    localparam int X_W    = width_of(IMG_WIDTH);
    localparam int Y_W    = width_of(IMG_HEIGHT);

    streamer_state_t state_reg, state_next;

    logic                 issue;
    logic                 emit;
    logic                 rd_pend_reg;
    logic                 skid_valid_reg;
    logic [ITEM_SIZE-1:0] skid_reg;
    logic [ITEM_SIZE-1:0] pixel_reg;
    logic                 pixel_valid_reg;
    logic [X_W-1:0]       pixel_x_reg;
    logic [Y_W-1:0]       pixel_y_reg;
    logic                 frame_start_reg;
    logic                 frame_end_reg;
    logic [ADDR_W-1:0]    addr_reg;

    logic [X_W-1:0] issue_x, out_x;
    logic [Y_W-1:0] issue_y, out_y;
    logic           issue_first, issue_last;
    logic           out_first, out_last;
    logic           unused_issue_xy;

    assign issue = (state_reg == STREAM) && !bus.stall;
    // A pending pixel is either in the skid or arriving from memory this cycle.
    assign emit  = !bus.stall && (skid_valid_reg || rd_pend_reg);

    assign unused_issue_xy = &{1'b0, issue_x, issue_y, issue_first};

    raster_xy_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT),
        .X_W       (X_W),
        .Y_W       (Y_W)
    ) u_issue_xy (
        .clk  (clk),
        .rst  (rst),
        .inc  (issue),
        .x    (issue_x),
        .y    (issue_y),
        .first(issue_first),
        .last (issue_last)
    );

    raster_xy_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT),
        .X_W       (X_W),
        .Y_W       (Y_W)
    ) u_out_xy (
        .clk  (clk),
        .rst  (rst),
        .inc  (emit),
        .x    (out_x),
        .y    (out_y),
        .first(out_first),
        .last (out_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = STREAM;
            STREAM:  if (issue && issue_last) state_next = DRAIN;
            // Leave only once the final pixel is visible on the output.
            DRAIN:   if (pixel_valid_reg && frame_end_reg) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_reg     <= 1'b0;
            skid_valid_reg  <= 1'b0;
            skid_reg        <= '0;
            pixel_reg       <= '0;
            pixel_valid_reg <= 1'b0;
            pixel_x_reg     <= '0;
            pixel_y_reg     <= '0;
            frame_start_reg <= 1'b0;
            frame_end_reg   <= 1'b0;
            addr_reg        <= '0;
        end else begin
            rd_pend_reg <= issue;
            if (issue) begin
                addr_reg <= issue_last ? '0 : addr_reg + 1'b1;
            end
            if (rd_pend_reg && bus.stall) begin
                skid_reg       <= bus.mem_rd_data;
                skid_valid_reg <= 1'b1;
            end
            if (emit) begin
                pixel_reg       <= skid_valid_reg ? skid_reg : bus.mem_rd_data;
                pixel_valid_reg <= 1'b1;
                skid_valid_reg  <= 1'b0;
                pixel_x_reg     <= out_x;
                pixel_y_reg     <= out_y;
                frame_start_reg <= out_first;
                frame_end_reg   <= out_last;
            end else begin
                pixel_valid_reg <= 1'b0;
                frame_start_reg <= 1'b0;
                frame_end_reg   <= 1'b0;
            end
        end
    end

    assign bus.mem_rd_en       = issue;
    assign bus.mem_addr        = addr_reg;
    assign bus.pixel_out       = pixel_reg;
    assign bus.pixel_out_valid = pixel_valid_reg;
    assign bus.pixel_x         = pixel_x_reg;
    assign bus.pixel_y         = pixel_y_reg;
    assign bus.frame_start     = frame_start_reg;
    assign bus.frame_end       = frame_end_reg;
    assign bus.busy            = (state_reg != IDLE);
    assign bus.done            = (state_reg == DONE);

endmodule

// File: tb/tb_image_pixel_streamer.sv
// Self-checking bench for image_pixel_streamer on a 4x3 frame with a 1-cycle sync ROM.
module tb_image_pixel_streamer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int IS = 8;
    localparam int N  = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    image_pixel_streamer_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ITEM_SIZE(IS)) bus ();

    image_pixel_streamer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ITEM_SIZE(IS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [IS-1:0] rom [N];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [IS-1:0] v;
        int            x;
        int            y;
        logic          fs;
        logic          fe;
        int            c;
    } rec_t;

    rec_t obs_q[$];
    int   done_q[$];
    bit   stall_pat[256];
    bit   start_pat[256];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_rd_en === 1'b1) bus.mem_rd_data <= rom[int'(bus.mem_addr) % N];
    end

    always @(negedge clk) begin
        if (bus.pixel_out_valid === 1'b1)
            obs_q.push_back('{bus.pixel_out, int'(bus.pixel_x), int'(bus.pixel_y),
                              bus.frame_start, bus.frame_end, cyc});
        if (bus.done === 1'b1) done_q.push_back(cyc);
    end

    task automatic clear_pats();
        for (int i = 0; i < 256; i++) begin
            stall_pat[i] = 1'b0;
            start_pat[i] = 1'b0;
        end
    endtask

    task automatic fill_rom(input bit ramp);
        for (int i = 0; i < N; i++) rom[i] = ramp ? IS'(i) : IS'($urandom_range(0, 255));
    endtask

    // Reference: once primed, each non-stalled cycle from start+2 emits the next raster pixel.
    task automatic run_frame(input string name, input int exp_done_off);
        int t0, k, c, done_c;
        int exp_c[$];
        obs_q.delete();
        done_q.delete();
        @(negedge clk);
        t0 = cyc;
        bus.start = 1'b1;
        bus.stall = stall_pat[0];
        k = 0;
        done_c = -1;
        while (1) begin
            @(negedge clk);
            k++;
            bus.start = start_pat[k];
            bus.stall = stall_pat[k];
            if (bus.done === 1'b1) begin
                done_c = cyc;
                break;
            end
            if (k >= 200) begin
                checks++; errors++;
                $display("FAIL %s timeout: done not seen within %0d cycles", name, k);
                break;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.stall = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_done: got %b want 0", name, bus.busy);
        end
        repeat (6) @(negedge clk);

        c = t0 + 2;
        while (exp_c.size() < N && c - t0 < 256) begin
            if (!stall_pat[c - t0]) exp_c.push_back(c + 1);
            c++;
        end

        checks++;
        if (obs_q.size() != N) begin
            errors++;
            $display("FAIL %s pixel_count: got %0d want %0d", name, obs_q.size(), N);
        end
        for (int i = 0; i < N && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].v !== rom[i] || obs_q[i].x != i % W || obs_q[i].y != i / W ||
                obs_q[i].fs !== (i == 0) || obs_q[i].fe !== (i == N - 1) ||
                obs_q[i].c != exp_c[i]) begin
                errors++;
                $display("FAIL %s pixel[%0d]: got v=%0d x=%0d y=%0d fs=%b fe=%b cyc=+%0d want v=%0d x=%0d y=%0d fs=%b fe=%b cyc=+%0d",
                         name, i, obs_q[i].v, obs_q[i].x, obs_q[i].y, obs_q[i].fs, obs_q[i].fe,
                         obs_q[i].c - t0, rom[i], i % W, i / W, i == 0, i == N - 1, exp_c[i] - t0);
            end
        end
        checks++;
        if (done_c != exp_c[N-1] + 1 || done_q.size() != 1) begin
            errors++;
            $display("FAIL %s done_cycle: got +%0d (pulses %0d) want +%0d (pulses 1)",
                     name, done_c - t0, done_q.size(), exp_c[N-1] + 1 - t0);
        end
        if (exp_done_off >= 0) begin
            checks++;
            if (done_c - t0 != exp_done_off) begin
                errors++;
                $display("FAIL %s done_latency: got +%0d want +%0d", name, done_c - t0, exp_done_off);
            end
        end
        $display("frame %s: %0d pixels, done at +%0d", name, obs_q.size(), done_c - t0);
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.start = 1'($urandom_range(0, 1));
            bus.stall = 1'($urandom_range(0, 1));
            outs = 32'({bus.mem_rd_en, bus.mem_addr, bus.pixel_out, bus.pixel_out_valid,
                        bus.pixel_x, bus.pixel_y, bus.frame_start, bus.frame_end,
                        bus.busy, bus.done});
            checks++;
            if (outs !== 32'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %h want 0", i, outs);
            end
            $display("reset cycle %0d: start=%b stall=%b outputs=%h", i, bus.start, bus.stall, outs);
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.pixel_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b valid=%b want 0 0", bus.busy, bus.pixel_out_valid);
        end
    endtask

    task automatic test_clean_frame();
        fill_rom(1'b1);
        clear_pats();
        run_frame("clean", 15);
    endtask

    task automatic test_single_stall();
        fill_rom(1'b0);
        clear_pats();
        stall_pat[6] = 1'b1;
        run_frame("single_stall", 16);
    endtask

    task automatic test_drain_stall();
        fill_rom(1'b0);
        clear_pats();
        for (int i = 13; i <= 17; i++) stall_pat[i] = 1'b1;
        start_pat[5]  = 1'b1;
        start_pat[20] = 1'b1;
        run_frame("drain_stall", 20);
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        fill_rom(1'b0);
        clear_pats();
        @(negedge clk);
        t0 = cyc;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < t0 + 8) @(negedge clk);
        checks++;
        if (bus.pixel_out_valid !== 1'b1 || bus.pixel_out !== rom[5]) begin
            errors++;
            $display("FAIL abort_pixel5: got valid=%b v=%0d want valid=1 v=%0d",
                     bus.pixel_out_valid, bus.pixel_out, rom[5]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.pixel_out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_after_rst: got valid=%b busy=%b want 0 0", bus.pixel_out_valid, bus.busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_restart: got busy=%b rd_en=%b want 0 0", bus.busy, bus.mem_rd_en);
        end
        $display("abort: reset at pixel 5, idle afterwards busy=%b", bus.busy);
        run_frame("replay", 15);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            fill_rom(1'b0);
            clear_pats();
            for (int i = 2; i < 60; i++) stall_pat[i] = ($urandom_range(0, 2) == 0);
            for (int i = 1; i < 60; i++) start_pat[i] = ($urandom_range(0, 3) == 0);
            run_frame($sformatf("random%0d", f), -1);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stall = 1'b0;
        test_reset();
        test_clean_frame();
        test_single_stall();
        test_drain_stall();
        test_reset_mid_frame();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
